// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order FIFO drain to data memory with youngest-match load forwarding.
// Build option: define STORE_BUF_COALESCE_EN to merge a store into the youngest entry on an address match.
module store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    input  logic [31:0]              st_addr,
    input  logic [31:0]              st_data,
    output logic                     st_ready,
    input  logic                     ld_valid,
    input  logic [31:0]              ld_addr,
    output logic                     ld_hit,
    output logic [31:0]              ld_data,
    output logic                     mem_we,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] C_FULL = DEPTH[PW:0];

    logic [31:0]   r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic          r_empty;
    logic          r_st_ready;

    logic          w_pop;
    logic          w_alloc;
    logic          w_coal;
    logic [PW-1:0] w_young;
    logic [PW:0]   w_count_nxt;
    logic          w_hit;
    logic [31:0]   w_fwd;
    logic [PW-1:0] w_idx;

    assign w_pop   = !r_empty && !ld_valid;
    assign w_young = r_tail - PW'(1);

`ifdef STORE_BUF_COALESCE_EN
    // Merging into an entry that is leaving this cycle would lose the store, so allocate instead.
    assign w_coal = st_valid && !r_empty
                 && (r_addr[w_young][31:2] == st_addr[31:2])
                 && !(w_pop && (r_count == (PW+1)'(1)));
`else
    assign w_coal = 1'b0;
`endif

    assign w_alloc = st_valid && r_st_ready && !w_coal;

    always_comb begin
        w_count_nxt = r_count;
        if (w_alloc && !w_pop) begin
            w_count_nxt = r_count + (PW+1)'(1);
        end else if (!w_alloc && w_pop) begin
            w_count_nxt = r_count - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_st_ready <= 1'b1;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_addr[PW'(i)] <= '0;
                r_data[PW'(i)] <= '0;
            end
        end else begin
            if (w_alloc) begin
                r_addr[r_tail] <= st_addr;
                r_data[r_tail] <= st_data;
                r_tail         <= r_tail + PW'(1);
            end else if (w_coal) begin
                r_data[w_young] <= st_data;
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            r_count    <= w_count_nxt;
            r_empty    <= (w_count_nxt == '0);
            r_st_ready <= (w_count_nxt != C_FULL);
        end
    end

    // Scan oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        w_hit = 1'b0;
        w_fwd = '0;
        w_idx = r_head;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PW'(k);
            if (((PW+1)'(k) < r_count) && (r_addr[w_idx][31:2] == ld_addr[31:2])) begin
                w_hit = 1'b1;
                w_fwd = r_data[w_idx];
            end
        end
    end

    assign st_ready  = r_st_ready;
    assign ld_hit    = w_hit;
    assign ld_data   = w_fwd;
    assign mem_we    = w_pop;
    assign mem_addr  = r_addr[r_head];
    assign mem_wdata = r_data[r_head];
    assign empty     = r_empty;
    assign count     = r_count;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference of buffer contents plus a vector table.
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;
`ifdef STORE_BUF_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        empty;
    logic [$clog2(DEPTH):0] count;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic [31:0] sd;
        logic        lv;
        logic [31:0] la;
        int          cnt;
        logic        hit;
        logic [31:0] ld;
    } vec_t;

    ent_t        mq[$];
    logic [31:0] tbmem [int];
    int          nw = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    vec_t        tbl[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, check outputs at the falling edge, advance the reference.
    task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                        input logic lv, input logic [31:0] la,
                        input bit tv, input int ecnt, input logic ehit, input logic [31:0] eld);
        logic        exp_we;
        logic        exp_ready;
        logic        fhit;
        logic [31:0] fdat;
        bit          coal;
        st_valid = sv; st_addr = sa; st_data = sd; ld_valid = lv; ld_addr = la;
        @(negedge clk);
        exp_ready = (mq.size() < DEPTH);
        exp_we    = (mq.size() != 0) && !lv;
        fhit = 1'b0;
        fdat = '0;
        foreach (mq[i]) begin
            if (mq[i].a[31:2] == la[31:2]) begin
                fhit = 1'b1;
                fdat = mq[i].d;
            end
        end
        chk("count", 32'(count), 32'(mq.size()));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("st_ready", 32'(st_ready), 32'(exp_ready));
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        if (mq.size() != 0) begin
            chk("mem_addr", mem_addr, mq[0].a);
            chk("mem_wdata", mem_wdata, mq[0].d);
        end
        if (lv) begin
            chk("ld_hit", 32'(ld_hit), 32'(fhit));
            chk("ld_data", ld_data, fdat);
        end
        if (tv) begin
            chk("tbl_count", 32'(count), 32'(ecnt));
            if (lv) begin
                chk("tbl_hit", 32'(ld_hit), 32'(ehit));
                chk("tbl_data", ld_data, eld);
            end
        end
        if (mem_we) begin
            tbmem[int'(mem_addr[31:2])] = mem_wdata;
            nw++;
        end
        coal = COAL && sv && (mq.size() != 0) && (mq[$].a[31:2] == sa[31:2])
            && !(exp_we && mq.size() == 1);
        if (exp_we) void'(mq.pop_front());
        if (coal) mq[$].d = sd;
        else if (sv && exp_ready) mq.push_back('{sa, sd});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, 0, 1'b0, '0);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic lv);
        step(1'b1, a, d, lv, a, 1'b0, 0, 1'b0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nsave;
        tbl[0]  = '{1'b1, 32'h20, 32'hA, 1'b1, 32'h20, 0, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 32'h24, 32'hB, 1'b1, 32'h20, 1, 1'b1, 32'hA};
        tbl[2]  = '{1'b1, 32'h20, 32'hC, 1'b1, 32'h24, 2, 1'b1, 32'hB};
        tbl[3]  = '{1'b0, 32'h0,  32'h0, 1'b1, 32'h22, 3, 1'b1, 32'hC};
        tbl[4]  = '{1'b0, 32'h0,  32'h0, 1'b1, 32'h28, 3, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 32'h0,  32'h0, 1'b1, 32'h24, 3, 1'b1, 32'hB};
        tbl[6]  = '{1'b0, 32'h0,  32'h0, 1'b0, 32'h0,  3, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 32'h30, 32'hD, 1'b0, 32'h0,  2, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 32'h34, 32'hE, 1'b0, 32'h0,  2, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 32'h0,  32'h0, 1'b0, 32'h0,  2, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 32'h0,  32'h0, 1'b0, 32'h0,  1, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 32'h0,  32'h0, 1'b0, 32'h0,  0, 1'b0, 32'h0};
        tbl[12] = '{1'b1, 32'h40, 32'h1, 1'b1, 32'h40, 0, 1'b0, 32'h0};
        tbl[13] = '{1'b1, 32'h40, 32'h2, 1'b1, 32'h40, 1, 1'b1, 32'h1};
        tbl[14] = '{1'b0, 32'h0,  32'h0, 1'b1, 32'h40, COAL ? 1 : 2, 1'b1, 32'h2};
        tbl[15] = '{1'b0, 32'h0,  32'h0, 1'b0, 32'h0,  COAL ? 1 : 2, 1'b0, 32'h0};
        tbl[16] = '{1'b0, 32'h0,  32'h0, 1'b0, 32'h0,  COAL ? 0 : 1, 1'b0, 32'h0};
        tbl[17] = '{1'b0, 32'h0,  32'h0, 1'b0, 32'h0,  0, 1'b0, 32'h0};

        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; ld_valid = 1'b0; ld_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ready", 32'(st_ready), 32'd1);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_hit", 32'(ld_hit), 32'd0);
        chk("rst_ldata", ld_data, 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        chk("rst_mwdata", mem_wdata, 32'd0);
        rst_n = 1'b1;

        // Single store drains one cycle after the push.
        st(32'h10, 32'h1234_5678, 1'b0);
        st_valid = 1'b0;
        #1;
        chk("single_we", 32'(mem_we), 32'd1);
        chk("single_addr", mem_addr, 32'h10);
        chk("single_wdata", mem_wdata, 32'h1234_5678);
        idle();
        chk("single_empty", 32'(empty), 32'd1);
        chk("single_mem", tbmem.exists(4) ? tbmem[4] : 32'hDEAD_BEEF, 32'h1234_5678);

        // Fill to FULL behind a held load, then drain in order.
        nsave = nw;
        for (int i = 0; i < 5; i++) st(32'(4 * i), 32'hF0 + 32'(i), 1'b1);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_ready", 32'(st_ready), 32'd0);
        chk("fill_nowrite", 32'(nw), 32'(nsave));
        repeat (5) idle();
        chk("fill_writes", 32'(nw - nsave), 32'd4);
        for (int i = 0; i < 4; i++) chk("fill_mem", tbmem.exists(i) ? tbmem[i] : 32'hDEAD_BEEF, 32'hF0 + 32'(i));
        chk("fill_5th_dropped", tbmem[4], 32'h1234_5678);

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].sv, tbl[i].sa, tbl[i].sd, tbl[i].lv, tbl[i].la, 1'b1, tbl[i].cnt, tbl[i].hit, tbl[i].ld);
        end
        chk("tbl_mem20", tbmem[8], 32'hC);
        chk("tbl_mem40", tbmem[16], 32'h2);

        // Concurrent push/pop at count 2, wrapping the pointers more than twice.
        nsave = nw;
        st(32'h100, 32'h5000, 1'b1);
        st(32'h104, 32'h5001, 1'b1);
        for (int k = 2; k < 12; k++) st(32'h100 + 32'(4 * k), 32'h5000 + 32'(k), 1'b0);
        chk("wrap_count", 32'(count), 32'd2);
        repeat (3) idle();
        chk("wrap_writes", 32'(nw - nsave), 32'd12);
        for (int k = 0; k < 12; k++) chk("wrap_mem", tbmem.exists(64 + k) ? tbmem[64 + k] : 32'hDEAD_BEEF, 32'h5000 + 32'(k));

        // Asynchronous reset while draining discards pending stores.
        for (int k = 0; k < 3; k++) st(32'h200 + 32'(4 * k), 32'h7000 + 32'(k), 1'b1);
        st_valid = 1'b0; ld_valid = 1'b0;
        #1;
        chk("prerst_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(mem_we), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_ready", 32'(st_ready), 32'd1);
        mq.delete();
        nsave = nw;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        idle();
        chk("arst_nowrite", 32'(nw - nsave), 32'd0);
        chk("arst_mem", tbmem.exists(128) ? 32'd1 : 32'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
